// File: rtl/alu_auftrag_steuerung_if.sv
// alu_auftrag_steuerung_if: decode job, ALU and writeback signals of the ALU issue sequencer
interface alu_auftrag_steuerung_if #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 6,
    parameter int ZIEL_W = 5
);
    logic              AuftragGueltig;
    logic              AuftragBereit;
    logic [CODE_W-1:0] AuftragCode;
    logic [DATA_W-1:0] AuftragDaten1;
    logic [DATA_W-1:0] AuftragDaten2;
    logic [ZIEL_W-1:0] AuftragZiel;
    logic [DATA_W-1:0] AluDaten1;
    logic [DATA_W-1:0] AluDaten2;
    logic [CODE_W-1:0] AluFunktionsCode;
    logic              AluStart;
    logic              AluReset;
    logic              AluFertig;
    logic [DATA_W-1:0] AluErgebnis;
    logic              ErgebnisGueltig;
    logic              ErgebnisBereit;
    logic [DATA_W-1:0] ErgebnisWert;
    logic [ZIEL_W-1:0] ErgebnisZiel;
    logic              ErgebnisFehler;

    modport slave (
        input  AuftragGueltig, AuftragCode, AuftragDaten1, AuftragDaten2, AuftragZiel,
               AluFertig, AluErgebnis, ErgebnisBereit,
        output AuftragBereit, AluDaten1, AluDaten2, AluFunktionsCode, AluStart, AluReset,
               ErgebnisGueltig, ErgebnisWert, ErgebnisZiel, ErgebnisFehler
    );

    modport master (
        output AuftragGueltig, AuftragCode, AuftragDaten1, AuftragDaten2, AuftragZiel,
               AluFertig, AluErgebnis, ErgebnisBereit,
        input  AuftragBereit, AluDaten1, AluDaten2, AluFunktionsCode, AluStart, AluReset,
               ErgebnisGueltig, ErgebnisWert, ErgebnisZiel, ErgebnisFehler
    );
endinterface

// File: rtl/alu_auftrag_steuerung.sv
// alu_auftrag_steuerung: issues one job to the ALU, masks stale done levels, guards with a
// timeout and hands the result with its destination to writeback.
module alu_auftrag_steuerung #(
    parameter int DATA_W   = 32,
    parameter int CODE_W   = 6,
    parameter int ZIEL_W   = 5,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 63
) (
    input logic Clock,
    input logic Reset,
    alu_auftrag_steuerung_if.slave Bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

    state_t            state, stateNext;
    logic [7:0]        cnt;
    logic [ZIEL_W-1:0] ziel;
    logic              accept, fertigOk, timeout, abgeholt;

    assign Bus.AuftragBereit = Reset & (state == IDLE | (state == RESULT & Bus.ErgebnisBereit));
    assign Bus.ErgebnisZiel  = ziel;
    assign accept   = Bus.AuftragGueltig & Bus.AuftragBereit;
    assign abgeholt = state == RESULT & Bus.ErgebnisBereit;
    // done is only trusted once the masking window has passed; a late done still beats timeout
    assign fertigOk = state == WAIT & cnt >= 8'(MIN_WAIT) & Bus.AluFertig;
    assign timeout  = state == WAIT & cnt == 8'(TIMEOUT) & ~Bus.AluFertig;

    always_comb begin
        stateNext = state;
        stateNext = accept              ? START  :
                    state == START      ? WAIT   :
                    fertigOk | timeout  ? RESULT :
                    abgeholt            ? IDLE   : state;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            ziel                 <= '0;
            Bus.AluDaten1        <= '0;
            Bus.AluDaten2        <= '0;
            Bus.AluFunktionsCode <= '0;
            Bus.AluStart         <= 1'b0;
            Bus.AluReset         <= 1'b0;
            Bus.ErgebnisGueltig  <= 1'b0;
            Bus.ErgebnisWert     <= '0;
            Bus.ErgebnisFehler   <= 1'b0;
        end else begin
            state        <= stateNext;
            Bus.AluStart <= accept;
            Bus.AluReset <= timeout;
            cnt <= state == START                ? 8'd1    :
                   state == WAIT && cnt != 8'hFF ? cnt + 1 : cnt;
            if (accept) begin
                Bus.AluDaten1        <= Bus.AuftragDaten1;
                Bus.AluDaten2        <= Bus.AuftragDaten2;
                Bus.AluFunktionsCode <= Bus.AuftragCode;
                ziel                 <= Bus.AuftragZiel;
            end
            if (fertigOk | timeout) begin
                Bus.ErgebnisGueltig <= 1'b1;
                Bus.ErgebnisWert    <= fertigOk ? Bus.AluErgebnis : '0;
                Bus.ErgebnisFehler  <= timeout;
            end else if (abgeholt) begin
                Bus.ErgebnisGueltig <= 1'b0;
            end
        end
    end
endmodule
